// File: rtl/int_stack_sequencer.sv
// int_stack_sequencer
//   Interrupt / CALL / RET / RTI stack sequencer. It pushes return PC and flags
//   onto a 16-bit-wide data-memory stack, pops them back, and hands the new PC
//   (and restored flags) to the fetch stage. The upstream pipeline is stalled
//   while a sequence is running.
//
// Parameters
//   SP_INIT     stack pointer value after reset
//   INT_VECTOR  PC loaded on interrupt entry
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   int_req                     external interrupt request (level)
//   call_req, ret_req, rti_req  decoded CALL / RET / RTI requests
//   call_target                 CALL destination PC
//   pc_in, flags_in             return PC and flags to save
//   mem_rdata                   memory read data, valid while mem_read is high
//   mem_addr, mem_wdata         memory address / write data
//   mem_read, mem_write         memory strobes
//   sp                          current stack pointer
//   int_counter, int_active     interrupt push phase (1..3) and its non-zero flag
//   pc_out, pc_load             new PC and its one-cycle load strobe
//   flags_out, flags_load       restored flags and their strobe
//   stall                       high whenever a sequence is in progress
module int_stack_sequencer #(
  parameter logic [31:0] SP_INIT    = 32'h0000_03FF,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic        rti_req,
  input  logic [31:0] call_target,
  input  logic [31:0] pc_in,
  input  logic [15:0] flags_in,
  input  logic [15:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] sp,
  output logic [1:0]  int_counter,
  output logic        int_active,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic [15:0] flags_out,
  output logic        flags_load,
  output logic        stall
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI
  } state_t;

  state_t      state;
  logic        pending_int;
  logic        mode;        // 1: interrupt entry, 0: CALL (only meaningful in push states)
  logic [15:0] lo_reg;
  logic [31:0] pc_cap;
  logic [15:0] flags_cap;
  logic [31:0] target_cap;

  // Stack pointer arithmetic wraps modulo 2^32 by construction.
  function automatic logic [31:0] sp_dec(input logic [31:0] v);
    return v - 32'd1;
  endfunction

  function automatic logic [31:0] sp_inc(input logic [31:0] v);
    return v + 32'd1;
  endfunction

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sp          <= SP_INIT;
      pending_int <= 1'b0;
      mode        <= 1'b0;
      lo_reg      <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (int_req || pending_int) begin
            state       <= PUSH_HI;
            mode        <= 1'b1;
            pending_int <= 1'b0;
          end else if (rti_req) begin
            state <= POP_FLG;
          end else if (ret_req) begin
            state <= POP_LO;
          end else if (call_req) begin
            state <= PUSH_HI;
            mode  <= 1'b0;
          end
        end
        PUSH_HI: begin
          sp    <= sp_dec(sp);
          state <= PUSH_LO;
        end
        PUSH_LO: begin
          sp    <= sp_dec(sp);
          state <= mode ? PUSH_FLG : IDLE;
        end
        PUSH_FLG: begin
          sp    <= sp_dec(sp);
          state <= IDLE;
        end
        POP_FLG: begin
          sp    <= sp_inc(sp);
          state <= POP_LO;
        end
        POP_LO: begin
          sp     <= sp_inc(sp);
          lo_reg <= mem_rdata;
          state  <= POP_HI;
        end
        POP_HI: begin
          sp    <= sp_inc(sp);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // An interrupt seen while busy is remembered and taken at the next IDLE.
      if (state != IDLE && int_req) pending_int <= 1'b1;
    end
  end

  // Operand capture: refreshed every IDLE cycle, so the values held during a
  // sequence are the ones present on its acceptance cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      pc_cap     <= pc_in;
      flags_cap  <= flags_in;
      target_cap <= call_target;
    end
  end

  // Output decode from the registered state
  always_comb begin
    mem_addr    = sp;
    mem_wdata   = 16'h0000;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    int_counter = 2'b00;
    pc_out      = 32'h0000_0000;
    pc_load     = 1'b0;
    flags_out   = 16'h0000;
    flags_load  = 1'b0;
    unique case (state)
      IDLE: ;
      PUSH_HI: begin
        mem_write   = 1'b1;
        mem_wdata   = pc_cap[31:16];
        int_counter = mode ? 2'b01 : 2'b00;
      end
      PUSH_LO: begin
        mem_write   = 1'b1;
        mem_wdata   = pc_cap[15:0];
        int_counter = mode ? 2'b10 : 2'b00;
        if (!mode) begin
          pc_load = 1'b1;
          pc_out  = target_cap;
        end
      end
      PUSH_FLG: begin
        mem_write   = 1'b1;
        mem_wdata   = flags_cap;
        int_counter = 2'b11;
        pc_load     = 1'b1;
        pc_out      = INT_VECTOR;
      end
      POP_FLG: begin
        mem_read   = 1'b1;
        mem_addr   = sp_inc(sp);
        flags_load = 1'b1;
        flags_out  = mem_rdata;
      end
      POP_LO: begin
        mem_read = 1'b1;
        mem_addr = sp_inc(sp);
      end
      POP_HI: begin
        mem_read = 1'b1;
        mem_addr = sp_inc(sp);
        pc_load  = 1'b1;
        pc_out   = {mem_rdata, lo_reg};
      end
      default: ;
    endcase
  end

  assign int_active = (int_counter != 2'b00);
  assign stall      = (state != IDLE);

endmodule

// File: tb/tb_int_stack_sequencer.sv
module tb_int_stack_sequencer;

  localparam logic [31:0] SP_INIT    = 32'h0000_03FF;
  localparam logic [31:0] INT_VECTOR = 32'h0000_0020;
  localparam int OP_INT  = 0;
  localparam int OP_CALL = 1;
  localparam int OP_RET  = 2;
  localparam int OP_RTI  = 3;

  logic        clk = 1'b0;
  logic        rst, int_req, call_req, ret_req, rti_req;
  logic [31:0] call_target, pc_in;
  logic [15:0] flags_in, mem_rdata;
  logic [31:0] mem_addr, sp, pc_out;
  logic [15:0] mem_wdata, flags_out;
  logic        mem_read, mem_write, int_active, pc_load, flags_load, stall;
  logic [1:0]  int_counter;

  int_stack_sequencer #(.SP_INIT(SP_INIT), .INT_VECTOR(INT_VECTOR)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .call_req(call_req),
    .ret_req(ret_req), .rti_req(rti_req), .call_target(call_target),
    .pc_in(pc_in), .flags_in(flags_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .sp(sp), .int_counter(int_counter),
    .int_active(int_active), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load), .stall(stall)
  );

  always #5 clk = ~clk;

  // Small data memory, indexed by the low address byte.
  logic [15:0] tbmem [256];
  assign mem_rdata = mem_read ? tbmem[mem_addr[7:0]] : 16'hDEAD;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  ic;
  } acc_t;

  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [15:0] flg;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [15:0] eflg;
    logic [31:0] esp;
  } vec_t;

  acc_t        acc_q[$];
  logic [31:0] pc_q[$];
  logic [15:0] flg_q[$];
  logic [31:0] model_sp;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare whatever the DUT presents in the new cycle
  // against the scoreboard queues.
  task automatic tick();
    acc_t e;
    @(posedge clk);
    #1;
    if (mem_write || mem_read) begin
      if (acc_q.size() == 0) begin
        chk("spurious_access", 32'd1, 32'd0);
      end else begin
        e = acc_q.pop_front();
        chk("acc_write", {31'd0, mem_write}, {31'd0, e.wr});
        chk("acc_addr", mem_addr, e.addr);
        if (e.wr) chk("acc_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
        chk("int_counter", {30'd0, int_counter}, {30'd0, e.ic});
        chk("int_active", {31'd0, int_active}, {31'd0, (e.ic != 2'b00)});
      end
      if (mem_write) tbmem[mem_addr[7:0]] = mem_wdata;
    end
    if (pc_load) begin
      if (pc_q.size() == 0) chk("spurious_pc_load", 32'd1, 32'd0);
      else chk("pc_out", pc_out, pc_q.pop_front());
    end
    if (flags_load) begin
      if (flg_q.size() == 0) chk("spurious_flags_load", 32'd1, 32'd0);
      else chk("flags_out", {16'd0, flags_out}, {16'd0, flg_q.pop_front()});
    end
    if (!stall) begin
      chk("idle_strobes", {27'd0, mem_read, mem_write, pc_load, flags_load, int_active}, 32'd0);
    end
  endtask

  task automatic exp_push(input logic [15:0] d, input logic [1:0] ic);
    acc_q.push_back('{1'b1, model_sp, d, ic});
    model_sp = model_sp - 32'd1;
  endtask

  task automatic exp_pop();
    acc_q.push_back('{1'b0, model_sp + 32'd1, 16'h0000, 2'b00});
    model_sp = model_sp + 32'd1;
  endtask

  task automatic do_reset();
    acc_q.delete();
    pc_q.delete();
    flg_q.delete();
    {int_req, call_req, ret_req, rti_req} = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_sp = SP_INIT;
  endtask

  // One complete operation: queue expectations, pulse the request(s) for the
  // acceptance cycle, then follow the busy period to IDLE.
  task automatic run_op(input int op, input logic [31:0] pc, input logic [15:0] flg,
                        input logic [31:0] tgt, input logic [31:0] epc,
                        input logic [15:0] eflg, input logic also_call);
    int n;
    int busy;
    pc_in = pc;
    flags_in = flg;
    call_target = tgt;
    case (op)
      OP_INT: begin
        exp_push(pc[31:16], 2'b01); exp_push(pc[15:0], 2'b10); exp_push(flg, 2'b11);
        busy = 3;
      end
      OP_CALL: begin
        exp_push(pc[31:16], 2'b00); exp_push(pc[15:0], 2'b00);
        busy = 2;
      end
      OP_RET: begin
        exp_pop(); exp_pop();
        busy = 2;
      end
      default: begin
        exp_pop(); flg_q.push_back(eflg); exp_pop(); exp_pop();
        busy = 3;
      end
    endcase
    pc_q.push_back(epc);
    int_req  = (op == OP_INT);
    call_req = (op == OP_CALL) || also_call;
    ret_req  = (op == OP_RET);
    rti_req  = (op == OP_RTI);
    tick();
    {int_req, call_req, ret_req, rti_req} = 4'b0000;
    n = 0;
    while (stall && n < 10) begin
      tick();
      n++;
    end
    chk("op_done", {31'd0, stall}, 32'd0);
    chk("latency", n, busy);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("pc_q_drained", pc_q.size(), 0);
    chk("flg_q_drained", flg_q.size(), 0);
    chk("sp", sp, model_sp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{OP_INT,  32'h0001_0040, 16'h0005, 32'h0, INT_VECTOR,    16'h0000, 32'h0000_03FC};
    tbl[1] = '{OP_RTI,  32'h0,         16'h0000, 32'h0, 32'h0001_0040, 16'h0005, 32'h0000_03FF};
    tbl[2] = '{OP_CALL, 32'h1234_5678, 16'h0000, 32'h0000_0100, 32'h0000_0100, 16'h0000, 32'h0000_03FD};
    tbl[3] = '{OP_INT,  32'h0000_0104, 16'h00A5, 32'h0, INT_VECTOR,    16'h0000, 32'h0000_03FA};
    tbl[4] = '{OP_RTI,  32'h0,         16'h0000, 32'h0, 32'h0000_0104, 16'h00A5, 32'h0000_03FD};
    tbl[5] = '{OP_RET,  32'h0,         16'h0000, 32'h0, 32'h1234_5678, 16'h0000, 32'h0000_03FF};

    for (int i = 0; i < 256; i++) tbmem[i] = 16'h0000;
    pc_in = 32'h0; flags_in = 16'h0; call_target = 32'h0;

    // Reset state
    do_reset();
    chk("rst_sp", sp, SP_INIT);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ic", {30'd0, int_counter}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_flags_out", {16'd0, flags_out}, 32'd0);
    chk("rst_strobes", {28'd0, mem_read, mem_write, pc_load, flags_load}, 32'd0);

    // Table-driven operations
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].pc, tbl[i].flg, tbl[i].tgt, tbl[i].epc, tbl[i].eflg, 1'b0);
      chk("tbl_sp", sp, tbl[i].esp);
    end

    // RET and CALL together: RET wins, no pushes
    run_op(OP_CALL, 32'hCAFE_BEEF, 16'h0, 32'h0000_0300, 32'h0000_0300, 16'h0, 1'b0);
    run_op(OP_RET, 32'h0000_0555, 16'h0, 32'h0000_0400, 32'hCAFE_BEEF, 16'h0, 1'b1);
    chk("ret_wins_sp", sp, 32'h0000_03FF);

    // Interrupt during CALL PUSH_HI is deferred to the next IDLE
    do_reset();
    pc_in = 32'h0000_1000; call_target = 32'h0000_2000;
    exp_push(16'h0000, 2'b00); exp_push(16'h1000, 2'b00);
    pc_q.push_back(32'h0000_2000);
    call_req = 1'b1;
    tick();
    call_req = 1'b0;
    int_req = 1'b1; pc_in = 32'h0000_3000; flags_in = 16'h0011;
    exp_push(16'h0000, 2'b01); exp_push(16'h3000, 2'b10); exp_push(16'h0011, 2'b11);
    pc_q.push_back(INT_VECTOR);
    tick();
    int_req = 1'b0;
    chk("defer_busy_lo", {31'd0, stall}, 32'd1);
    tick();
    chk("defer_idle_gap", {31'd0, stall}, 32'd0);
    tick();
    chk("defer_int_start", {31'd0, stall}, 32'd1);
    tick(); tick(); tick();
    chk("defer_done", {31'd0, stall}, 32'd0);
    chk("defer_q", acc_q.size() + pc_q.size(), 0);
    chk("defer_sp", sp, 32'h0000_03FA);

    // Drive sp down to zero, then wrap through 0 in both directions
    do_reset();
    run_op(OP_INT, 32'h0000_0001, 16'h0001, 32'h0, INT_VECTOR, 16'h0, 1'b0);
    for (int i = 0; i < 510; i++) begin
      run_op(OP_CALL, 32'h0000_0000 + i, 16'h0, 32'h0000_0800 + i, 32'h0000_0800 + i, 16'h0, 1'b0);
    end
    chk("wrap_sp_zero", sp, 32'h0000_0000);
    run_op(OP_CALL, 32'h7654_3210, 16'h0, 32'h0000_0900, 32'h0000_0900, 16'h0, 1'b0);
    chk("wrap_sp_down", sp, 32'hFFFF_FFFE);
    run_op(OP_RET, 32'h0, 16'h0, 32'h0, 32'h7654_3210, 16'h0, 1'b0);
    chk("wrap_sp_up", sp, 32'h0000_0000);

    // Reset in POP_LO with an interrupt pending: abort, no pc_load, no interrupt
    do_reset();
    run_op(OP_INT, 32'h0000_ABCD, 16'h0077, 32'h0, INT_VECTOR, 16'h0, 1'b0);
    exp_pop(); flg_q.push_back(16'h0077); exp_pop();
    rti_req = 1'b1;
    tick();
    rti_req = 1'b0;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_sp = SP_INIT;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_sp", sp, SP_INIT);
    chk("abort_pc_load", {31'd0, pc_load}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_pending", {31'd0, stall}, 32'd0);
    end
    chk("abort_q", acc_q.size() + pc_q.size() + flg_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_stack_sequencer.md
INT_STACK_SEQUENCER -- requirements
Module: int_stack_sequencer

Interface
REQ-001 Parameter SP_INIT, default 32'h0000_03FF, is the stack pointer value after reset.
REQ-002 Parameter INT_VECTOR, default 32'h0000_0020, is the PC loaded on interrupt entry.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port int_req  input  1  is the external interrupt request (level).
REQ-006 Port call_req, ret_req, rti_req  input  1 each  are decoded CALL/RET/RTI requests from EX/MEM.
REQ-007 Port call_target  input  32  is the CALL destination PC.
REQ-008 Port pc_in  input  32  is the return PC to save.
REQ-009 Port flags_in  input  16  is the flag register to save.
REQ-010 Port mem_rdata  input  16  is data memory read data, valid in the same cycle mem_read is high.
REQ-011 Port mem_addr  output  32  is the data memory address.
REQ-012 Port mem_wdata  output  16  is the data memory write data.
REQ-013 Port mem_read, mem_write  output  1 each  are the memory strobes.
REQ-014 Port sp  output  32  is the current stack pointer (registered).
REQ-015 Port int_counter  output  2  is the interrupt push phase; int_active  output  1  is high during interrupt push states.
REQ-016 Port pc_out  output  32 and pc_load  output  1  carry the new PC with its one-cycle load strobe.
REQ-017 Port flags_out  output  16 and flags_load  output  1  carry the restored flags with their strobe.
REQ-018 Port stall  output  1  freezes upstream pipeline stages whenever the block is not IDLE.

Function
REQ-019 States SHALL be IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI; the state register is the only sequencing storage besides sp, pending_int, mode and lo_reg.
REQ-020 In IDLE, requests SHALL be arbitrated with fixed priority int_req (or pending_int) > rti_req > ret_req > call_req; only the winner is accepted.
REQ-021 An accepted interrupt or CALL SHALL go IDLE->PUSH_HI->PUSH_LO; an interrupt then continues ->PUSH_FLG->IDLE, while a CALL returns to IDLE.
REQ-022 An accepted RTI SHALL go IDLE->POP_FLG->POP_LO->POP_HI->IDLE; an accepted RET SHALL go IDLE->POP_LO->POP_HI->IDLE.
REQ-023 Push states SHALL drive mem_write=1 and mem_addr=sp, then set sp<=sp-1. Data SHALL be pc_in[31:16] in PUSH_HI, pc_in[15:0] in PUSH_LO and flags_in in PUSH_FLG, with pc_in and flags_in captured at acceptance.
REQ-024 Pop states SHALL drive mem_read=1 and mem_addr=sp+1, then set sp<=sp+1.
REQ-025 POP_FLG SHALL assert flags_load with flags_out=mem_rdata; POP_LO SHALL capture mem_rdata into lo_reg.
REQ-026 pc_load SHALL pulse exactly once per operation, in the final state, with pc_out as follows:
  - interrupt (PUSH_FLG): INT_VECTOR
  - CALL (PUSH_LO): captured call_target
  - RET/RTI (POP_HI): {mem_rdata, lo_reg}
REQ-027 int_counter SHALL be 2'b01 in PUSH_HI, 2'b10 in PUSH_LO and 2'b11 in PUSH_FLG during an interrupt, and 2'b00 otherwise; int_active = (int_counter != 0).
REQ-028 stall SHALL equal (state != IDLE); mem_read, mem_write, pc_load and flags_load SHALL be 0 in IDLE.
REQ-029 Latency: interrupt and RTI busy 3 cycles; CALL and RET busy 2 cycles; a new request is accepted on the cycle the block returns to IDLE.
REQ-030 An int_req arriving while not IDLE SHALL set pending_int. pending_int is serviced at the next IDLE and cleared on acceptance.
REQ-031 Requests other than interrupts arriving while not IDLE SHALL be ignored; stall guarantees the requester holds them.
REQ-032 sp arithmetic SHALL be modulo 2^32 (0-1 wraps to 32'hFFFF_FFFF, 32'hFFFF_FFFF+1 wraps to 0), with no error flag.

Reset
REQ-033 With rst=1 at a clock edge, the block SHALL set:
  - state=IDLE, sp=SP_INIT
  - pending_int=0, lo_reg=0
  - all strobes=0, int_counter=0, pc_out=0, flags_out=0
REQ-034 Reset mid-operation SHALL abort the sequence with no further memory access or pc_load, and SHALL drop pending interrupts.

Verification
REQ-035 Reset, then pulse int_req with pc_in=32'h0001_0040 and flags_in=16'h0005 -> writes 0001@3FF, 0040@3FE, 0005@3FD; int_counter 1,2,3; pc_load with 32'h20; sp=3FC.
REQ-036 Following REQ-035, raise rti_req -> reads 3FD, 3FE, 3FF; flags_out=0005; pc_out=32'h0001_0040; sp=3FF.
REQ-037 call_req and ret_req asserted together in IDLE -> RET wins (two pops); CALL is not executed.
REQ-038 int_req pulsed during a CALL in PUSH_HI -> CALL completes; interrupt entry begins on the next IDLE cycle.
REQ-039 sp=32'h0000_0000 with CALL -> sp goes 0 -> FFFF_FFFF -> FFFF_FFFE.
REQ-040 rst asserted in POP_LO -> next cycle IDLE with sp=3FF and no pc_load.
